// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encodings, default datapath widths and the
// writeback sequencer state type.
package cpu_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_MOV  = 3'b010,
    ALU_SWAP = 3'b011,
    ALU_AND  = 3'b100,
    ALU_OR   = 3'b101
  } alu_op_t;

  typedef enum logic {
    WB_IDLE   = 1'b0,
    WB_SECOND = 1'b1
  } wb_state_t;

endpackage

// File: rtl/swap_writeback_seq.sv
// Writeback sequencer between the EX/MEM->WB register and a single-write-port
// register file. Unpacks the packed ALU result {Result2, Result1}. Ordinary ops
// issue one write; SWAP issues two back-to-back writes and stalls upstream for
// one cycle while the second write is pending.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready decoded from state)
//   alu_control           request op, only SWAP is decoded
//   reg_write             request writes the register file at all
//   result                {Result2, Result1}
//   rd1 / rd2             destinations of Result1 / Result2 (rd2 used by SWAP)
//   flush                 drops incoming request or pending second write
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
//   busy                  second SWAP write pending
module swap_writeback_seq
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter logic [2:0]  OP_SWAP = ALU_SWAP
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            alu_control,
  input  logic                  reg_write,
  input  logic [2*DATA_W-1:0]   result,
  input  logic [ADDR_W-1:0]     rd1,
  input  logic [ADDR_W-1:0]     rd2,
  input  logic                  flush,
  output logic                  rf_we,
  output logic [ADDR_W-1:0]     rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  busy
);

  wb_state_t           state_q, state_d;
  logic [DATA_W-1:0]   hold_data_q, hold_data_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic                we_d;
  logic [ADDR_W-1:0]   waddr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                accept;
  logic                is_swap;

  assign in_ready = (state_q == WB_IDLE);
  assign busy     = (state_q == WB_SECOND);
  assign accept   = in_valid & in_ready & ~flush;
  assign is_swap  = (alu_control == OP_SWAP);

  // State, holding and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= WB_IDLE;
      hold_data_q <= '0;
      hold_addr_q <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_addr_q <= hold_addr_d;
      rf_we       <= we_d;
      rf_waddr    <= waddr_d;
      rf_wdata    <= wdata_d;
    end
  end

  // Next-state logic; flush takes priority over accept and the pending write.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WB_IDLE: begin
        if (accept && reg_write && is_swap) state_d = WB_SECOND;
      end
      WB_SECOND: begin
        state_d = WB_IDLE;
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Next values of the write port and SWAP holding registers.
  always_comb begin
    we_d        = 1'b0;
    waddr_d     = rf_waddr;
    wdata_d     = rf_wdata;
    hold_data_d = hold_data_q;
    hold_addr_d = hold_addr_q;
    unique case (state_q)
      WB_IDLE: begin
        if (accept && reg_write) begin
          we_d    = 1'b1;
          waddr_d = rd1;
          wdata_d = result[DATA_W-1:0];
          if (is_swap) begin
            hold_data_d = result[2*DATA_W-1:DATA_W];
            hold_addr_d = rd2;
          end
        end
      end
      WB_SECOND: begin
        if (!flush) begin
          we_d    = 1'b1;
          waddr_d = hold_addr_q;
          wdata_d = hold_data_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_swap_writeback_seq.sv
module tb_swap_writeback_seq;
  import cpu_pkg::*;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          alu_control;
  logic                reg_write;
  logic [2*DATA_W-1:0] result;
  logic [ADDR_W-1:0]   rd1;
  logic [ADDR_W-1:0]   rd2;
  logic                flush;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic                busy;

  int n_checks = 0;
  int n_errors = 0;

  swap_writeback_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .OP_SWAP(3'b011)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .reg_write  (reg_write),
    .result     (result),
    .rd1        (rd1),
    .rd2        (rd2),
    .flush      (flush),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] ctl, input logic rw, input logic [31:0] res,
                     input logic [3:0] a1, input logic [3:0] a2);
    in_valid    = 1'b1;
    alu_control = ctl;
    reg_write   = rw;
    result      = res;
    rd1         = a1;
    rd2         = a2;
  endtask

  task automatic wr(input string tag, input logic we, input logic [3:0] a, input logic [15:0] d);
    chk({tag, ".we"},   32'(rf_we),    32'(we));
    chk({tag, ".addr"}, 32'(rf_waddr), 32'(a));
    chk({tag, ".data"}, 32'(rf_wdata), 32'(d));
  endtask

  task automatic hs(input string tag, input logic rdy, input logic bsy);
    chk({tag, ".ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, ".busy"},  32'(busy),     32'(bsy));
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; alu_control = 3'b000; reg_write = 1'b0;
    result = '0; rd1 = '0; rd2 = '0; flush = 1'b0;
    #12;
    wr("reset", 1'b0, 4'd0, 16'h0000);
    hs("reset", 1'b1, 1'b0);
    step();
    reset_n = 1'b1;
    step();

    // 1. ADD: single write of Result1, upper half ignored
    req(3'b000, 1'b1, 32'hDEAD_1234, 4'd3, 4'd9);
    step();
    wr("add", 1'b1, 4'd3, 16'h1234);
    hs("add", 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    wr("add_idle", 1'b0, 4'd3, 16'h1234);

    // 2. SWAP: two writes, one stall cycle
    req(3'b011, 1'b1, 32'h00AA_00BB, 4'd2, 4'd5);
    step();
    wr("swap1", 1'b1, 4'd2, 16'h00BB);
    hs("swap1", 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    wr("swap2", 1'b1, 4'd5, 16'h00AA);
    hs("swap2", 1'b1, 1'b0);
    step();
    wr("swap3", 1'b0, 4'd5, 16'h00AA);
    hs("swap3", 1'b1, 1'b0);

    // 3. SWAP to the same register: Result1 then Result2
    req(3'b011, 1'b1, 32'h1111_2222, 4'd7, 4'd7);
    step();
    wr("same1", 1'b1, 4'd7, 16'h2222);
    in_valid = 1'b0;
    step();
    wr("same2", 1'b1, 4'd7, 16'h1111);

    // 4. SWAP without reg_write: nothing written, no stall
    req(3'b011, 1'b0, 32'h5555_6666, 4'd1, 4'd2);
    step();
    wr("norw", 1'b0, 4'd7, 16'h1111);
    hs("norw", 1'b1, 1'b0);
    in_valid = 1'b0;
    step();
    hs("norw2", 1'b1, 1'b0);

    // 5. SWAP then MOV held valid through the stall
    req(3'b011, 1'b1, 32'h0044_0011, 4'd1, 4'd4);
    step();
    wr("b2b1", 1'b1, 4'd1, 16'h0011);
    hs("b2b1", 1'b0, 1'b1);
    req(3'b010, 1'b1, 32'hFFFF_0099, 4'd9, 4'd0);
    step();
    wr("b2b2", 1'b1, 4'd4, 16'h0044);
    hs("b2b2", 1'b1, 1'b0);
    step();
    wr("b2b3", 1'b1, 4'd9, 16'h0099);
    in_valid = 1'b0;
    step();
    wr("b2b4", 1'b0, 4'd9, 16'h0099);

    // 6a. flush in SECOND drops the pending write, first write stands
    req(3'b011, 1'b1, 32'h0088_0066, 4'd6, 4'd8);
    step();
    wr("fl1", 1'b1, 4'd6, 16'h0066);
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    wr("fl2", 1'b0, 4'd6, 16'h0066);
    hs("fl2", 1'b1, 1'b0);
    flush = 1'b0;

    // 6b. flush in IDLE drops the incoming request
    req(3'b000, 1'b1, 32'h0000_ABCD, 4'd11, 4'd0);
    flush = 1'b1;
    step();
    wr("fli", 1'b0, 4'd6, 16'h0066);
    hs("fli", 1'b1, 1'b0);
    flush = 1'b0;
    in_valid = 1'b0;
    step();

    // 6c. reset in SECOND clears outputs before the next edge
    req(3'b011, 1'b1, 32'h0033_0022, 4'd12, 4'd13);
    step();
    hs("rs1", 1'b0, 1'b1);
    in_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    wr("rs2", 1'b0, 4'd0, 16'h0000);
    hs("rs2", 1'b1, 1'b0);
    step();
    reset_n = 1'b1;
    step();
    wr("rs3", 1'b0, 4'd0, 16'h0000);
    hs("rs3", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
